// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the iterative shift-add multiplier.
// Early termination is controlled by the MULT_EARLY_TERM_EN macro in the modules.
package mult_pkg;

  localparam int MULT_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Counter width for a given operand width; never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_w(MULT_DATA_W);

endpackage

// File: rtl/mult_ctrl.sv
// Multiplier sequencer: IDLE/RUN/DONE FSM, iteration counter and exit decision.
// With MULT_EARLY_TERM_EN defined, RUN also exits once the remaining multiplier bits are zero.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int DATA_W = MULT_DATA_W
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic              flush,
`ifdef MULT_EARLY_TERM_EN
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:1] mplier_hi,
`endif
  output logic              accept,
  output logic              step,
  output logic              load_result,
  output logic              clr,
  output logic              busy,
  output logic              done
);

  localparam int CW = cnt_w(DATA_W);

  mult_state_t   state, state_nxt;
  logic [CW-1:0] cnt;
  logic          last_step;
  logic          zero_op;

`ifdef MULT_EARLY_TERM_EN
  assign zero_op   = (op_b == '0);
  assign last_step = (cnt == CW'(DATA_W - 1)) || (mplier_hi == '0);
`else
  assign zero_op   = 1'b0;
  assign last_step = (cnt == CW'(DATA_W - 1));
`endif

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    step        = 1'b0;
    load_result = 1'b0;
    clr         = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (flush) begin
          state_nxt = IDLE;
          clr       = 1'b1;
        end else if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
          if (zero_op) begin
            state_nxt   = DONE;
            load_result = 1'b1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (flush) begin
          state_nxt = IDLE;
          clr       = 1'b1;
        end else begin
          step = 1'b1;
          if (last_step) begin
            state_nxt   = DONE;
            load_result = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        clr       = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
      if (clr || accept) begin
        cnt <= '0;
      end else if (step) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_unit.sv
// Iterative shift-add multiplier, low DATA_W bits of op_a*op_b with a done pulse.
// Define MULT_EARLY_TERM_EN for data-dependent latency.
module mult_unit
  import mult_pkg::*;
#(
  parameter int DATA_W = MULT_DATA_W
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] acc, mcand, mplier;
  logic [DATA_W-1:0] acc_step;
  logic              accept, step, load_result, clr;

  mult_ctrl #(.DATA_W(DATA_W)) u_ctrl (
    .clk         (clk),
    .arst_n      (arst_n),
    .start       (start),
    .flush       (flush),
`ifdef MULT_EARLY_TERM_EN
    .op_b        (op_b),
    .mplier_hi   (mplier[DATA_W-1:1]),
`endif
    .accept      (accept),
    .step        (step),
    .load_result (load_result),
    .clr         (clr),
    .busy        (busy),
    .done        (done)
  );

  // Accumulator after this cycle's step, wrapping modulo 2^DATA_W.
  assign acc_step = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      result <= '0;
    end else begin
      if (clr) begin
        acc    <= '0;
        mcand  <= '0;
        mplier <= '0;
      end else if (accept) begin
        acc    <= '0;
        mcand  <= op_a;
        mplier <= op_b;
      end else if (step) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      // A zero multiplier under early termination enters DONE straight from accept.
      if (load_result) begin
        result <= step ? acc_step : '0;
      end
    end
  end

endmodule
